time_report_tx: RTL
===================

TIME_REPORT_TX -- requirements
Module: time_report_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 50, meaning clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port report_req  input  1  single-cycle request to transmit one time report.
REQ-005 SHALL have ports hour, minute, second  input  8 each  binary time fields.
REQ-006 SHALL have ports day  input  5, month  input  4, year  input  12  binary date fields.
REQ-007 SHALL have port tx  output  1  UART serial line, idle high.
REQ-008 SHALL have port busy  output  1  high while a report is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a report completes.

Function
REQ-010 SHALL accept report_req only when busy=0; a request while busy=0 is accepted in that cycle, including the cycle done=1.
REQ-011 SHALL snapshot all six fields on acceptance; later input changes do not affect the report in progress.
REQ-012 SHALL transmit exactly 21 ASCII bytes: "HH:MM:SS DD/MM/YYYY" followed by 0x0D, 0x0A.
REQ-013 SHALL render each two-digit field as (value mod 100) in decimal, zero-padded; year as (value mod 10000), four digits, zero-padded.
REQ-014 SHALL frame each byte 8N1: start bit 0, data bits LSB first, stop bit 1, each bit held exactly CLKS_PER_BIT cycles.
REQ-015 SHALL send bytes back-to-back, with no idle bits between stop bit and next start bit.
REQ-016 SHALL drive tx low and busy high starting the cycle after acceptance (latency 1).
REQ-017 SHALL deassert busy and pulse done for one cycle in the cycle after the final stop bit's last cycle; a full report spans 210*CLKS_PER_BIT cycles of busy.
REQ-018 SHALL use FSM states IDLE -> START -> DATA (8 bits) -> STOP -> START for the next byte, or -> IDLE after byte 20.
REQ-019 SHALL silently ignore report_req while busy=1, with no queuing.
REQ-020 SHALL hold tx=1 in IDLE.

Reset
REQ-021 SHALL, on rst, force state IDLE, tx=1, busy=0, done=0, byte index 0, bit and baud counters 0.
REQ-022 SHALL let rst win over a simultaneous report_req.
REQ-023 SHALL, on rst mid-frame, return tx to 1 on the next cycle and discard the partial report without pulsing done.

Structure
REQ-024 SHALL place the CLKS_PER_BIT default, REPORT_LEN=21, the ASCII constants (':', ' ', '/', CR, LF, '0') and the FSM state encoding in shared package clock_cal_pkg.
REQ-025 SHALL implement byte serialization in sub-module uart_tx_byte (byte/valid in, tx/ready out); time_report_tx sequences bytes and performs decimal conversion.

Verification
REQ-026 SHALL cover: CLKS_PER_BIT=4; inputs 18/30/0, 30/7/2024; single report_req -> bytes "18:30:00 30/07/2024\r\n", busy high for 840 cycles, then done=1 for one cycle.
REQ-027 SHALL cover: inputs 0/59/59, 1/12/999 -> "00:59:59 01/12/0999\r\n"; inputs hour=123, year=4095 -> hour field "23", year field "4095".
REQ-028 SHALL cover: report_req asserted every cycle during a report -> exactly one report, with the next accepted in the done cycle and its start bit following immediately.
REQ-029 SHALL cover: all inputs changed at byte 5 -> transmitted text equals the snapshot taken at acceptance.
REQ-030 SHALL cover: rst asserted in the middle of byte 10 data -> tx=1 and busy=0 the next cycle, no done pulse; a fresh request then yields a full correct report.
REQ-031 SHALL cover: rst and report_req in the same cycle -> remains IDLE, tx=1.

Source files
------------

// File: rtl/clock_cal_pkg.sv
// Shared constants, FSM encoding and ASCII rendering helpers for the time report transmitter.
`timescale 1ns/1ps
package clock_cal_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 50;
  localparam int unsigned REPORT_LEN           = 21;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // Serializer states: IDLE -> START -> DATA (8 bits) -> STOP -> START/IDLE
  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // Least significant decimal digit of v as an ASCII character.
  function automatic logic [7:0] ascii_digit(input int unsigned v);
    return ASCII_ZERO + 8'(v % 10);
  endfunction

  // Character at position idx of "HH:MM:SS DD/MM/YYYY\r\n".
  function automatic logic [7:0] report_char(input logic [4:0]  idx,
                                             input logic [7:0]  hh,
                                             input logic [7:0]  mm,
                                             input logic [7:0]  ss,
                                             input logic [4:0]  dd,
                                             input logic [3:0]  mo,
                                             input logic [11:0] yy);
    int unsigned h2, m2, s2, d2, o2, y4;
    logic [7:0]  c;
    h2 = 32'(hh) % 100;
    m2 = 32'(mm) % 100;
    s2 = 32'(ss) % 100;
    d2 = 32'(dd) % 100;
    o2 = 32'(mo) % 100;
    y4 = 32'(yy) % 10000;
    case (idx)
      5'd0:    c = ascii_digit(h2 / 10);
      5'd1:    c = ascii_digit(h2);
      5'd2:    c = ASCII_COLON;
      5'd3:    c = ascii_digit(m2 / 10);
      5'd4:    c = ascii_digit(m2);
      5'd5:    c = ASCII_COLON;
      5'd6:    c = ascii_digit(s2 / 10);
      5'd7:    c = ascii_digit(s2);
      5'd8:    c = ASCII_SPACE;
      5'd9:    c = ascii_digit(d2 / 10);
      5'd10:   c = ascii_digit(d2);
      5'd11:   c = ASCII_SLASH;
      5'd12:   c = ascii_digit(o2 / 10);
      5'd13:   c = ascii_digit(o2);
      5'd14:   c = ASCII_SLASH;
      5'd15:   c = ascii_digit(y4 / 1000);
      5'd16:   c = ascii_digit(y4 / 100);
      5'd17:   c = ascii_digit(y4 / 10);
      5'd18:   c = ascii_digit(y4);
      5'd19:   c = ASCII_CR;
      5'd20:   c = ASCII_LF;
      default: c = ASCII_SPACE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; accepts the next byte in the last stop-bit cycle so bytes run back-to-back.
`timescale 1ns/1ps
module uart_tx_byte
  import clock_cal_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       tx,
  output logic       ready
);

  localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        baud_last;

  assign baud_last = (baud_q == BaudLast);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state: baud count within a bit, bit count within the data phase
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    baud_d  = baud_last ? 16'd0 : baud_q + 16'd1;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        if (byte_valid) begin
          state_d = StStart;
          shift_d = byte_data;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (baud_last) state_d = StData;
      end
      StData: begin
        if (baud_last) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (baud_last) begin
          if (byte_valid) begin
            state_d = StStart;
            shift_d = byte_data;
            bit_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: line level per state, handshake ready at the byte boundary
  always_comb begin
    tx    = 1'b1;
    ready = 1'b0;
    unique case (state_q)
      StIdle:  begin tx = 1'b1; ready = 1'b1; end
      StStart: tx = 1'b0;
      StData:  tx = shift_q[0];
      StStop:  begin tx = 1'b1; ready = baud_last; end
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/time_report_tx.sv
// Sends one "HH:MM:SS DD/MM/YYYY\r\n" report over UART per accepted request.
`timescale 1ns/1ps
module time_report_tx
  import clock_cal_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        report_req,
  input  logic [7:0]  hour,
  input  logic [7:0]  minute,
  input  logic [7:0]  second,
  input  logic [4:0]  day,
  input  logic [3:0]  month,
  input  logic [11:0] year,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LastIdx = 5'(REPORT_LEN);

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  hour_q, minute_q, second_q;
  logic [4:0]  day_q;
  logic [3:0]  month_q;
  logic [11:0] year_q;

  logic        accept;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;

  assign accept = report_req && !busy_q;

  // The first byte goes out in the accept cycle, so it is rendered from the live inputs.
  always_comb begin
    tx_valid = accept || (busy_q && (idx_q < LastIdx));
    if (accept) tx_data = report_char(5'd0, hour, minute, second, day, month, year);
    else        tx_data = report_char(idx_q, hour_q, minute_q, second_q, day_q, month_q, year_q);
  end

  // Byte sequencing: idx_q is the next byte to hand over; reaching LastIdx at a ready means
  // the final stop bit just ended.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    idx_d  = idx_q;
    if (accept) begin
      busy_d = 1'b1;
      idx_d  = 5'd1;
    end else if (busy_q && tx_ready) begin
      if (idx_q == LastIdx) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + 5'd1;
      end
    end
  end

  // Sequencer state and field snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
      hour_q   <= '0;
      minute_q <= '0;
      second_q <= '0;
      day_q    <= '0;
      month_q  <= '0;
      year_q   <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      idx_q  <= idx_d;
      if (accept) begin
        hour_q   <= hour;
        minute_q <= minute;
        second_q <= second;
        day_q    <= day;
        month_q  <= month;
        year_q   <= year;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk       (clk),
    .rst       (rst),
    .byte_data (tx_data),
    .byte_valid(tx_valid),
    .tx        (tx),
    .ready     (tx_ready)
  );

endmodule
